// File: rtl/video_timing_ctrl_if.sv
// ============================================================================
// Module   : video_timing_ctrl_if
// Brief    : Pixel-source and encoder-side signal bundle for video_timing_ctrl.
//            master = timing controller, slave = source/encoder side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_timing_ctrl_if #(
  parameter int X_WIDTH = 11,
  parameter int Y_WIDTH = 10
);
  // Pixel-source side: coordinates out, colour back
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic               active;
  logic               frame_start;
  logic               line_start;
  logic [7:0]         r_in;
  logic [7:0]         g_in;
  logic [7:0]         b_in;

  // Encoder side: aligned colour and timing
  logic [7:0]         r_out;
  logic [7:0]         g_out;
  logic [7:0]         b_out;
  logic               de;
  logic               hsync;
  logic               vsync;

  modport master (
    output x, y, active, frame_start, line_start,
    input  r_in, g_in, b_in,
    output r_out, g_out, b_out, de, hsync, vsync
  );

  modport slave (
    input  x, y, active, frame_start, line_start,
    output r_in, g_in, b_in,
    input  r_out, g_out, b_out, de, hsync, vsync
  );
endinterface

`default_nettype wire

// File: rtl/video_timing_ctrl.sv
// ============================================================================
// Module   : video_timing_ctrl
// Brief    : Raster timing controller. Scans h/v counters, hands (x, y) to the
//            pixel source, registers the returned RGB and delays DE/HSYNC/VSYNC
//            so they line up with the colour data.
//            Optional macro VIDEO_TIMING_CTRL_BLANK_EN: when defined, RGB
//            outputs are forced to zero whenever the aligned DE is low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_ctrl #(
  parameter int HOR_ACTIVE_PIXELS = 1280,
  parameter int HOR_FRONT_PORCH   = 110,
  parameter int HOR_SYNC          = 40,
  parameter int HOR_BACK_PORCH    = 220,
  parameter int VER_ACTIVE_PIXELS = 720,
  parameter int VER_FRONT_PORCH   = 5,
  parameter int VER_SYNC          = 5,
  parameter int VER_BACK_PORCH    = 20,
  parameter int HSYNC_ACTIVE_HIGH = 1,
  parameter int VSYNC_ACTIVE_HIGH = 1,
  parameter int PIXEL_LATENCY     = 0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              ce,
  video_timing_ctrl_if.master    bus
);

  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
  localparam int X_WIDTH = (HOR_ACTIVE_PIXELS > 1) ? $clog2(HOR_ACTIVE_PIXELS) : 1;
  localparam int Y_WIDTH = (VER_ACTIVE_PIXELS > 1) ? $clog2(VER_ACTIVE_PIXELS) : 1;
  localparam int H_WIDTH = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_WIDTH = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam int HS_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
  localparam int HS_END   = HS_START + HOR_SYNC;
  localparam int VS_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
  localparam int VS_END   = VS_START + VER_SYNC;

  localparam logic [H_WIDTH-1:0] c_H_LAST = H_WIDTH'(H_TOTAL - 1);
  localparam logic [V_WIDTH-1:0] c_V_LAST = V_WIDTH'(V_TOTAL - 1);
  localparam logic               c_HS_ON  = (HSYNC_ACTIVE_HIGH != 0);
  localparam logic               c_VS_ON  = (VSYNC_ACTIVE_HIGH != 0);
  // Delay-line idle word: {de, hsync, vsync} all deasserted
  localparam logic [2:0]         c_DLY_IDLE = {1'b0, ~c_HS_ON, ~c_VS_ON};

  // Reject degenerate rasters and out-of-range latency at elaboration time
  if (HOR_ACTIVE_PIXELS <= 0 || VER_ACTIVE_PIXELS <= 0) begin : g_bad_active
    $error("video_timing_ctrl: active width/height must be non-zero");
  end
  if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 15) begin : g_bad_latency
    $error("video_timing_ctrl: PIXEL_LATENCY must be 0..15");
  end

  logic [H_WIDTH-1:0] r_h_cnt;
  logic [V_WIDTH-1:0] r_v_cnt;
  logic [2:0]         r_dly [PIXEL_LATENCY+1];
  logic [7:0]         r_r, r_g, r_b;

  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_de_next;
  int   w_h;
  int   w_v;

  assign w_h      = int'(r_h_cnt);
  assign w_v      = int'(r_v_cnt);
  assign w_active = (w_h < HOR_ACTIVE_PIXELS) && (w_v < VER_ACTIVE_PIXELS);
  assign w_hs_raw = (w_h >= HS_START) && (w_h < HS_END);
  assign w_vs_raw = (w_v >= VS_START) && (w_v < VS_END);

  // Raster scan: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (ce) begin
      if (r_h_cnt == c_H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Timing shift line; polarity is applied on entry so outputs come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= PIXEL_LATENCY; i++) r_dly[i] <= c_DLY_IDLE;
    end else if (ce) begin
      r_dly[0] <= {w_active,
                   w_hs_raw ? c_HS_ON : ~c_HS_ON,
                   w_vs_raw ? c_VS_ON : ~c_VS_ON};
      for (int i = 1; i <= PIXEL_LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // DE value that the output stage will present after the next ce edge
  if (PIXEL_LATENCY == 0) begin : g_de_lat0
    assign w_de_next = w_active;
  end else begin : g_de_latn
    assign w_de_next = r_dly[PIXEL_LATENCY-1][2];
  end

  // Colour capture, optionally blanked so RGB is zero whenever DE is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end else if (ce) begin
`ifdef VIDEO_TIMING_CTRL_BLANK_EN
      r_r <= w_de_next ? bus.r_in : 8'h00;
      r_g <= w_de_next ? bus.g_in : 8'h00;
      r_b <= w_de_next ? bus.b_in : 8'h00;
`else
      r_r <= bus.r_in;
      r_g <= bus.g_in;
      r_b <= bus.b_in;
`endif
    end
  end

  assign bus.x           = w_active ? r_h_cnt[X_WIDTH-1:0] : '0;
  assign bus.y           = w_active ? r_v_cnt[Y_WIDTH-1:0] : '0;
  assign bus.active      = w_active;
  assign bus.line_start  = (r_h_cnt == '0);
  assign bus.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign bus.de          = r_dly[PIXEL_LATENCY][2];
  assign bus.hsync       = r_dly[PIXEL_LATENCY][1];
  assign bus.vsync       = r_dly[PIXEL_LATENCY][0];
  assign bus.r_out       = r_r;
  assign bus.g_out       = r_g;
  assign bus.b_out       = r_b;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
// ============================================================================
// Module   : tb_video_timing_ctrl
// Brief    : Directed bench for video_timing_ctrl on a 14x7 raster. One DUT
//            runs with PIXEL_LATENCY=0, a second with PIXEL_LATENCY=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic src_const = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef VIDEO_TIMING_CTRL_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  always #5 clk = ~clk;

  video_timing_ctrl_if #(.X_WIDTH(3), .Y_WIDTH(2)) bus0 ();
  video_timing_ctrl_if #(.X_WIDTH(3), .Y_WIDTH(2)) bus3 ();

  video_timing_ctrl #(
    .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(2), .HOR_SYNC(2), .HOR_BACK_PORCH(2),
    .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1),
    .HSYNC_ACTIVE_HIGH(1), .VSYNC_ACTIVE_HIGH(1), .PIXEL_LATENCY(0)
  ) dut0 (.clk(clk), .rst(rst), .ce(ce), .bus(bus0));

  video_timing_ctrl #(
    .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(2), .HOR_SYNC(2), .HOR_BACK_PORCH(2),
    .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1),
    .HSYNC_ACTIVE_HIGH(1), .VSYNC_ACTIVE_HIGH(1), .PIXEL_LATENCY(3)
  ) dut3 (.clk(clk), .rst(rst), .ce(ce), .bus(bus3));

  // Pixel sources: dut0 sees a combinational source, dut3 a 3-cycle one
  logic [7:0] r_pipe [3];
  assign bus0.r_in = src_const ? 8'hFF : {5'b0, bus0.x};
  assign bus0.g_in = {6'b0, bus0.y};
  assign bus0.b_in = 8'h5A;
  assign bus3.r_in = r_pipe[2];
  assign bus3.g_in = 8'h00;
  assign bus3.b_in = 8'h00;

  always_ff @(posedge clk) begin
    if (ce) begin
      r_pipe[0] <= {5'b0, bus3.x};
      r_pipe[1] <= r_pipe[0];
      r_pipe[2] <= r_pipe[1];
    end
  end

  // Reference raster for counter step n after reset:
  // {x[2:0], y[1:0], active, frame_start, line_start, hsync_raw, vsync_raw}
  function automatic logic [9:0] exp_raw(input int n);
    int h, v;
    logic act;
    h   = n % 14;
    v   = (n / 14) % 7;
    act = (h < 8) && (v < 4);
    exp_raw[9:7] = act ? 3'(h) : 3'd0;
    exp_raw[6:5] = act ? 2'(v) : 2'd0;
    exp_raw[4]   = act;
    exp_raw[3]   = (h == 0) && (v == 0);
    exp_raw[2]   = (h == 0);
    exp_raw[1]   = (h >= 10) && (h < 12);
    exp_raw[0]   = (v == 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({bus0.x, bus0.y, bus0.active, bus0.frame_start, bus0.line_start} !== 8'b000_00_111) begin
      n_err++;
      $display("FAIL reset_front got=%b exp=%b",
               {bus0.x, bus0.y, bus0.active, bus0.frame_start, bus0.line_start}, 8'b000_00_111);
    end
    n_vec++;
    if ({bus0.de, bus0.hsync, bus0.vsync} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_sync0 got=%b exp=000", {bus0.de, bus0.hsync, bus0.vsync});
    end
    n_vec++;
    if ({bus0.r_out, bus0.g_out, bus0.b_out} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_rgb0 got=%h exp=000000", {bus0.r_out, bus0.g_out, bus0.b_out});
    end
    n_vec++;
    if ({bus3.de, bus3.hsync, bus3.vsync, bus3.r_out} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_dut3 got=%h exp=000", {bus3.de, bus3.hsync, bus3.vsync, bus3.r_out});
    end
  endtask

  task automatic test_raster();
    logic [9:0] e, p;
    logic [7:0] eb;
    do_reset();
    for (int t = 0; t <= 98; t++) begin
      e  = exp_raw(t);
      p  = (t > 0) ? exp_raw(t - 1) : 10'b0;
      eb = ((t > 0) && (!BLANK || p[4])) ? 8'h5A : 8'h00;
      n_vec++;
      if ({bus0.x, bus0.y, bus0.active, bus0.frame_start, bus0.line_start} !== e[9:2]) begin
        n_err++;
        $display("FAIL raster_front t=%0d got=%b exp=%b", t,
                 {bus0.x, bus0.y, bus0.active, bus0.frame_start, bus0.line_start}, e[9:2]);
      end
      n_vec++;
      if ({bus0.de, bus0.hsync, bus0.vsync} !== {p[4], p[1], p[0]}) begin
        n_err++;
        $display("FAIL raster_sync t=%0d got=%b exp=%b", t,
                 {bus0.de, bus0.hsync, bus0.vsync}, {p[4], p[1], p[0]});
      end
      n_vec++;
      if ({bus0.r_out, bus0.g_out, bus0.b_out} !== {5'b0, p[9:7], 6'b0, p[6:5], eb}) begin
        n_err++;
        $display("FAIL raster_rgb t=%0d got=%h exp=%h", t,
                 {bus0.r_out, bus0.g_out, bus0.b_out}, {5'b0, p[9:7], 6'b0, p[6:5], eb});
      end
      step();
    end
  endtask

  task automatic test_latency();
    logic [9:0] q;
    do_reset();
    for (int t = 0; t < 196; t++) begin
      q = (t >= 4) ? exp_raw(t - 4) : 10'b0;
      n_vec++;
      if ({bus3.de, bus3.hsync, bus3.vsync} !== {q[4], q[1], q[0]}) begin
        n_err++;
        $display("FAIL lat3_sync t=%0d got=%b exp=%b", t,
                 {bus3.de, bus3.hsync, bus3.vsync}, {q[4], q[1], q[0]});
      end
      if (q[4]) begin
        n_vec++;
        if (bus3.r_out !== {5'b0, q[9:7]}) begin
          n_err++;
          $display("FAIL lat3_rgb t=%0d got=%h exp=%h", t, bus3.r_out, {5'b0, q[9:7]});
        end
      end
      step();
    end
  endtask

  task automatic test_ce_toggle();
    int n;
    logic [9:0] e, p;
    do_reset();
    n = 0;
    for (int k = 0; k < 196; k++) begin
      ce = (k % 2 == 0);
      step();
      if (ce) n++;
      e = exp_raw(n);
      p = (n > 0) ? exp_raw(n - 1) : 10'b0;
      n_vec++;
      if ({bus0.x, bus0.y, bus0.active, bus0.frame_start, bus0.line_start} !== e[9:2]) begin
        n_err++;
        $display("FAIL ce_front k=%0d got=%b exp=%b", k,
                 {bus0.x, bus0.y, bus0.active, bus0.frame_start, bus0.line_start}, e[9:2]);
      end
      n_vec++;
      if ({bus0.de, bus0.hsync, bus0.vsync, bus0.r_out} !== {p[4], p[1], p[0], 5'b0, p[9:7]}) begin
        n_err++;
        $display("FAIL ce_out k=%0d got=%h exp=%h", k,
                 {bus0.de, bus0.hsync, bus0.vsync, bus0.r_out}, {p[4], p[1], p[0], 5'b0, p[9:7]});
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (80) step();
    // Now at h=10 on line 5: output shows the previous pixel (h=9, line 5)
    n_vec++;
    if ({bus0.hsync, bus0.vsync} !== 2'b01) begin
      n_err++;
      $display("FAIL mid_pre got=%b exp=01", {bus0.hsync, bus0.vsync});
    end
    rst = 1'b1;
    ce  = 1'b0;
    step();
    rst = 1'b0;
    ce  = 1'b1;
    n_vec++;
    if ({bus0.x, bus0.y, bus0.frame_start} !== 6'b000_00_1) begin
      n_err++;
      $display("FAIL mid_front got=%b exp=000001", {bus0.x, bus0.y, bus0.frame_start});
    end
    n_vec++;
    if ({bus0.de, bus0.hsync, bus0.vsync, bus0.r_out, bus0.g_out, bus0.b_out} !== 27'h0) begin
      n_err++;
      $display("FAIL mid_out got=%h exp=0",
               {bus0.de, bus0.hsync, bus0.vsync, bus0.r_out, bus0.g_out, bus0.b_out});
    end
    step();
    n_vec++;
    if ({bus0.x, bus0.de, bus0.hsync, bus0.vsync} !== 6'b001_100) begin
      n_err++;
      $display("FAIL mid_resume got=%b exp=001100", {bus0.x, bus0.de, bus0.hsync, bus0.vsync});
    end
  endtask

  task automatic test_blank();
    logic [9:0] p;
    logic [7:0] er;
    src_const = 1'b1;
    do_reset();
    for (int t = 0; t < 98; t++) begin
      p  = (t > 0) ? exp_raw(t - 1) : 10'b0;
      er = ((t > 0) && (!BLANK || p[4])) ? 8'hFF : 8'h00;
      n_vec++;
      if (bus0.r_out !== er) begin
        n_err++;
        $display("FAIL blank_r t=%0d got=%h exp=%h", t, bus0.r_out, er);
      end
      step();
    end
    src_const = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raster();
    test_latency();
    test_ce_toggle();
    test_reset_mid();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Raster timing controller that sequences the per-pixel colour source (test pattern, game renderer).
- Scans horizontal/vertical counters, presents pixel coordinates (x, y) to the source, then registers the returned RGB.
- Delays DE/HSYNC/VSYNC so they stay aligned with the RGB output.
- Sits between the pixel-source datapath and the HDMI/DVI encoder.

Parameters:
- HOR_ACTIVE_PIXELS, 1280, visible pixels per line
- HOR_FRONT_PORCH, 110, pixel clocks after active, before hsync
- HOR_SYNC, 40, hsync width in pixel clocks
- HOR_BACK_PORCH, 220, pixel clocks after hsync
- VER_ACTIVE_PIXELS, 720, visible lines per frame
- VER_FRONT_PORCH, 5, lines
- VER_SYNC, 5, lines
- VER_BACK_PORCH, 20, lines
- HSYNC_ACTIVE_HIGH, 1, 1 = hsync asserted high, 0 = asserted low
- VSYNC_ACTIVE_HIGH, 1, same for vsync
- PIXEL_LATENCY, 0, clock cycles from x/y presentation to valid r_in/g_in/b_in (0..15)
- Derived localparams: X_WIDTH = $clog2(HOR_ACTIVE_PIXELS), Y_WIDTH = $clog2(VER_ACTIVE_PIXELS), H_TOTAL, V_TOTAL.

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- ce  input  1  pixel clock enable; all state advances only when ce=1
- x  output  X_WIDTH  current column to pixel source; 0 outside active region
- y  output  Y_WIDTH  current row to pixel source; 0 outside active region
- active  output  1  counters inside active region (undelayed, aligned with x/y)
- frame_start  output  1  high while h_cnt=0 and v_cnt=0 (undelayed)
- line_start  output  1  high while h_cnt=0 (undelayed)
- r_in, g_in, b_in  input  8 each  colour from pixel source
- r_out, g_out, b_out  output  8 each  registered colour to encoder
- de  output  1  data enable, aligned with r/g/b_out
- hsync  output  1  aligned with r/g/b_out, polarity per parameter
- vsync  output  1  aligned with r/g/b_out, polarity per parameter

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1 → 0.
  - Both hold when ce=0.
- Line order: active [0, HA), front porch, sync, back porch. Same order for the vertical.
  - hsync asserted for h_cnt in [HA+HFP, HA+HFP+HS).
  - vsync asserted for v_cnt in [VA+VFP, VA+VFP+VS), for whole lines (changes at h_cnt=0).
- active = (h_cnt < HA) && (v_cnt < VA).
  - x = active ? h_cnt : 0.
  - y = active ? v_cnt : 0.
  - Both are driven directly from counter registers; no added latency.
- Output alignment:
  - Internal shift line of depth PIXEL_LATENCY+1 carries {active, hsync_raw, vsync_raw}; it advances only on ce.
  - r/g/b_out register r/g/b_in on ce.
  - Net effect: de/hsync/vsync/rgb_out for the pixel at counter cycle t appear at ce-cycle t+PIXEL_LATENCY+1.
- Reset values:
  - h_cnt = v_cnt = 0, hence x = 0, y = 0, active = 1, frame_start = 1, line_start = 1.
  - Delay line cleared to de = 0 and hsync/vsync deasserted (inactive polarity).
  - r/g/b_out = 0.
- Reset asserted mid-frame: next cycle restarts at (0,0) and aborts any in-flight sync pulse. The output sync must not glitch to asserted.
- ce low during reset: reset still takes effect.
- Parameters with HA or VA = 0 are illegal; elaboration error via generate-time check.

Optional Feature:
- Macro: VIDEO_TIMING_CTRL_BLANK_EN.
- Defined: r/g/b_out are forced to 0 on any cycle where the delayed de is 0, independent of r/g/b_in.
- Undefined: r/g/b_out pass the registered r/g/b_in unconditionally. The encoder is responsible for ignoring blanking data.

Test Plan:
Use HA=8, HFP=2, HS=2, HBP=2 (H_TOTAL=14), VA=4, VFP=1, VS=1, VBP=1 (V_TOTAL=7), PIXEL_LATENCY=0, ce=1, unless noted.
- Reset then run 98 cycles:
  - x cycles 0..7 then 0 for six cycles.
  - frame_start high only at cycles 0 and 98.
  - line_start every 14 cycles.
- Raw/aligned sync:
  - hsync high exactly at h_cnt 10,11 of every line, appearing one cycle later at the output.
  - vsync high for all 14 cycles of line 5, delayed one cycle.
  - de high 8 cycles per line on lines 0..3 only.
- PIXEL_LATENCY=3, r_in = x delayed 3 cycles: r_out equals column index exactly while de=1, with de rising 4 cycles after line_start.
- ce toggled 1/0 each cycle: counters advance every other cycle; one full frame takes 196 cycles; outputs hold during ce=0.
- Assert rst for 1 cycle at h_cnt=10 on line 5 (sync active):
  - next cycle x=0, y=0, frame_start=1.
  - output hsync/vsync deasserted, de=0, rgb_out=0.
- BLANK_EN defined, r_in=8'hFF constant: r_out=0 whenever de=0 and FF when de=1. Undefined: r_out=FF from cycle 1 onwards.
